// File: rtl/lifo_stack.sv
// Parametrised LIFO stack with registered occupancy, replace-on-push+pop,
// sticky error flags and flush. Define LIFO_STACK_WRAP_EN for ring-overwrite on push-when-full.
module lifo_stack #(
  parameter int DATA_W = 12,
  parameter int DEPTH  = 8,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [DATA_W-1:0] push_data,
  output logic [DATA_W-1:0] tos_data,
  output logic [CNT_W-1:0]  count,
  output logic              empty,
  output logic              full,
  output logic              overflow,
  output logic              underflow
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int SUM_W = CNT_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [CNT_W-1:0]  cnt, cnt_next;
  logic              ovf_next, unf_next;
  logic              wr_en;
  logic [IDX_W-1:0]  wr_idx;
  logic [IDX_W-1:0]  push_idx, top_idx;
  logic [SUM_W-1:0]  base_ext, cnt_ext;

`ifdef LIFO_STACK_WRAP_EN
  logic [IDX_W-1:0]  base, base_next;
`else
  logic [IDX_W-1:0]  base;
  assign base = '0;
`endif

  // Sums never exceed 2*DEPTH-1, so one conditional subtract folds them into the ring.
  function automatic logic [IDX_W-1:0] ring(input logic [SUM_W-1:0] s);
    if (s >= SUM_W'(DEPTH))
      return IDX_W'(s - SUM_W'(DEPTH));
    return IDX_W'(s);
  endfunction

  assign base_ext = SUM_W'(base);
  assign cnt_ext  = SUM_W'(cnt);
  assign push_idx = ring(base_ext + cnt_ext);
  assign top_idx  = ring(base_ext + cnt_ext - SUM_W'(1));

  assign count    = cnt;
  assign empty    = (cnt == '0);
  assign full     = (cnt == CNT_W'(DEPTH));
  assign tos_data = (cnt != '0) ? mem[top_idx] : '0;

  always_comb begin
    cnt_next = cnt;
    ovf_next = overflow;
    unf_next = underflow;
    wr_en    = 1'b0;
    wr_idx   = push_idx;
`ifdef LIFO_STACK_WRAP_EN
    base_next = base;
`endif
    if (flush) begin
      cnt_next = '0;
      ovf_next = 1'b0;
      unf_next = 1'b0;
`ifdef LIFO_STACK_WRAP_EN
      base_next = '0;
`endif
    end else if (push && pop && !empty) begin
      wr_en  = 1'b1;
      wr_idx = top_idx;
    end else if (push && !full) begin
      // Also covers push+pop on an empty stack, which must not raise underflow.
      wr_en    = 1'b1;
      cnt_next = cnt + 1'b1;
    end else if (push) begin
`ifdef LIFO_STACK_WRAP_EN
      // When full, push_idx lands on the oldest slot; advancing base makes it the top.
      wr_en     = 1'b1;
      base_next = ring(base_ext + SUM_W'(1));
`else
      ovf_next = 1'b1;
`endif
    end else if (pop && !empty) begin
      cnt_next = cnt - 1'b1;
    end else if (pop) begin
      unf_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      cnt       <= cnt_next;
      overflow  <= ovf_next;
      underflow <= unf_next;
    end
  end

`ifdef LIFO_STACK_WRAP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      base <= '0;
    else
      base <= base_next;
  end
`endif

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_idx] <= push_data;
  end

endmodule

// File: tb/tb_lifo_stack.sv
// Directed self-checking bench for lifo_stack (DEPTH=8, DATA_W=12); expectations
// follow LIFO_STACK_WRAP_EN when it is defined for the build.
module tb_lifo_stack;

  logic        clk;
  logic        rst_n;
  logic        push;
  logic        pop;
  logic        flush;
  logic [11:0] push_data;
  logic [11:0] tos_data;
  logic [3:0]  count;
  logic        empty;
  logic        full;
  logic        overflow;
  logic        underflow;

  int total_checks = 0;
  int bad_checks   = 0;

  lifo_stack dut (
    .clk(clk),
    .rst_n(rst_n),
    .push(push),
    .pop(pop),
    .flush(flush),
    .push_data(push_data),
    .tos_data(tos_data),
    .count(count),
    .empty(empty),
    .full(full),
    .overflow(overflow),
    .underflow(underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst_n)
      assert (!$isunknown({push, pop})) else $error("[TB] push/pop unknown while out of reset");
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total_checks++;
    if (observed !== expected) begin
      bad_checks++;
      $display("[TB] FAIL %s: observed=0x%0h required=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic checkState(input string tag, input int exp_count, input int exp_tos,
                            input bit exp_ovf, input bit exp_unf);
    checkOutput({tag, ".count"}, 32'(count), 32'(exp_count));
    checkOutput({tag, ".tos"}, 32'(tos_data), 32'(exp_tos));
    checkOutput({tag, ".empty"}, 32'(empty), 32'(exp_count == 0));
    checkOutput({tag, ".full"}, 32'(full), 32'(exp_count == 8));
    checkOutput({tag, ".ovf"}, 32'(overflow), 32'(exp_ovf));
    checkOutput({tag, ".unf"}, 32'(underflow), 32'(exp_unf));
  endtask

  // Drive one cycle of inputs, let the edge take them, then return 1 ns after it.
  task automatic applyStimulus(input bit p_push, input bit p_pop, input bit p_flush, input logic [11:0] data);
    push      = p_push;
    pop       = p_pop;
    flush     = p_flush;
    push_data = data;
    @(posedge clk);
    #1;
    push      = 1'b0;
    pop       = 1'b0;
    flush     = 1'b0;
    push_data = '0;
  endtask

  initial begin
    rst_n     = 1'b0;
    push      = 1'b0;
    pop       = 1'b0;
    flush     = 1'b0;
    push_data = '0;
    repeat (2) @(posedge clk);
    #1;
    checkState("reset", 0, 0, 0, 0);
    rst_n = 1'b1;

    applyStimulus(1, 0, 0, 12'h111);
    checkState("push1", 1, 12'h111, 0, 0);
    applyStimulus(1, 0, 0, 12'h222);
    applyStimulus(1, 0, 0, 12'h333);
    checkState("push3", 3, 12'h333, 0, 0);
    applyStimulus(0, 1, 0, 12'h000);
    checkState("pop1", 2, 12'h222, 0, 0);

    applyStimulus(0, 0, 1, 12'h000);
    checkState("flush1", 0, 0, 0, 0);
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(1, 0, 0, 12'(i));
      if (i == 7) checkState("fill7", 7, 7, 0, 0);
    end
    checkState("fill8", 8, 8, 0, 0);
    applyStimulus(1, 0, 0, 12'h009);
`ifdef LIFO_STACK_WRAP_EN
    checkState("wrap_push", 8, 9, 0, 0);
    for (int i = 0; i < 8; i++) begin
      checkOutput("wrap_pop_tos", 32'(tos_data), 32'(9 - i));
      applyStimulus(0, 1, 0, 12'h000);
    end
    checkState("wrap_drained", 0, 0, 0, 0);
`else
    checkState("ovf_push", 8, 8, 1, 0);
    for (int i = 0; i < 8; i++) begin
      checkOutput("drain_pop_tos", 32'(tos_data), 32'(8 - i));
      applyStimulus(0, 1, 0, 12'h000);
    end
    checkState("drained", 0, 0, 1, 0);
`endif

    applyStimulus(0, 0, 1, 12'h000);
    checkState("flush2", 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 12'h0A0);
    applyStimulus(1, 0, 0, 12'h0B0);
    applyStimulus(1, 1, 0, 12'h0C0);
    checkState("replace", 2, 12'h0C0, 0, 0);
    applyStimulus(0, 1, 0, 12'h000);
    checkState("replace_pop", 1, 12'h0A0, 0, 0);

    applyStimulus(0, 0, 1, 12'h000);
    applyStimulus(0, 1, 0, 12'h000);
    checkState("unf_pop", 0, 0, 0, 1);
    applyStimulus(1, 0, 0, 12'h055);
    checkState("unf_sticky", 1, 12'h055, 0, 1);
    applyStimulus(0, 0, 1, 12'h000);
    checkState("unf_flush", 0, 0, 0, 0);

    applyStimulus(1, 1, 0, 12'h123);
    checkState("pushpop_empty", 1, 12'h123, 0, 0);

    for (int i = 0; i < 4; i++)
      applyStimulus(1, 0, 0, 12'h200 + 12'(i));
    checkState("five", 5, 12'h203, 0, 0);
    applyStimulus(1, 0, 1, 12'h777);
    checkState("flush_push", 0, 0, 0, 0);

    applyStimulus(1, 0, 0, 12'h301);
    applyStimulus(1, 0, 0, 12'h302);
    applyStimulus(1, 0, 0, 12'h303);
    checkState("pre_reset", 3, 12'h303, 0, 0);
    push      = 1'b1;
    push_data = 12'h444;
    #2;
    rst_n = 1'b0;
    #1;
    checkState("async_reset", 0, 0, 0, 0);
    push      = 1'b0;
    push_data = '0;
    #1;
    rst_n = 1'b1;
    applyStimulus(1, 0, 0, 12'h3FF);
    checkState("post_reset", 1, 12'h3FF, 0, 0);

    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule

// File: doc/lifo_stack.md
Name: lifo_stack

Overview:
- Parametrised LIFO stack: the successor to the fixed 8x12 call stack in the MMIPS control path. Holds return addresses and other saved values for the controller.
- Depth and data width are configurable. Adds registered full/empty/count status, a same-cycle replace of the top entry (push+pop), sticky overflow/underflow error flags and a synchronous flush.
- Fully synchronous to one clock; async active-low reset.

Parameters:
- DATA_W, 12, width of each entry in bits.
- DEPTH, 8, number of entries; legal range 2..256.
- CNT_W, $clog2(DEPTH+1), width of the occupancy count; derived, never overridden.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- push  input  1  write push_data as the new top entry.
- pop  input  1  remove the top entry.
- flush  input  1  synchronous clear of all contents.
- push_data  input  DATA_W  data to push.
- tos_data  output  DATA_W  current top-of-stack value; 0 when empty.
- count  output  CNT_W  number of valid entries.
- empty  output  1  count==0.
- full  output  1  count==DEPTH.
- overflow  output  1  sticky: a push was rejected.
- underflow  output  1  sticky: a pop was rejected.

Behaviour:
- Reset (rst_n low, async): count=0, empty=1, full=0, overflow=0, underflow=0, tos_data=0. Storage array contents are not reset.
- Storage is a DEPTH x DATA_W register array. Pointer sp is equal to count; the top entry is at index sp-1.
- tos_data is combinational from the array and sp: data[sp-1] if count>0, else 0.
- A push or pop at edge N is visible on tos_data, count and flags after edge N, i.e. one-cycle latency.
- Per-edge priority, highest first:
  - 1. flush=1: count←0; overflow and underflow are cleared. push and pop are ignored that cycle.
  - 2. push=1 and pop=1, count>0: replace. data[sp-1]←push_data, count unchanged.
  - 3. push=1 and pop=1, count==0: treated as a plain push; underflow is not set.
  - 4. push only, not full: data[sp]←push_data, count+1.
  - 5. push only, full: see Optional Feature.
  - 6. pop only, count>0: count−1. The entry stays in the array but is no longer visible.
  - 7. pop only, empty: count is unchanged and underflow←1.
- overflow and underflow stay at 1 until flush or reset.
- empty and full are decoded from count, so they are consistent with count every cycle.
- X on push or pop is a protocol error. The bench asserts these inputs are never X while rst_n=1.
- Reset asserted mid-operation: the in-flight push or pop is discarded and outputs return to their reset values immediately.

Optional Feature:
- Macro: LIFO_STACK_WRAP_EN.
- Defined: a push while full is accepted as a circular overwrite, acting as a return-address stack that discards the oldest entry.
  - The storage is addressed as a ring, with base index b and top index (b+count-1) mod DEPTH.
  - On push-when-full, b←(b+1) mod DEPTH and the new entry is written at the old base slot. It becomes the top.
  - count stays DEPTH and overflow is not set.
  - Pops after wrap return entries newest-first. After DEPTH pops the stack is empty; the discarded entries are never returned.
- Undefined: push-when-full is rejected. The array and count are unchanged and overflow←1. No ring logic is synthesised (b is constant 0).

Test Plan:
- Reset, then push 0x111, 0x222, 0x333 on consecutive cycles -> count=3, tos_data=0x333; pop -> tos_data=0x222, count=2.
- From empty, push 8 values 0x001..0x008 (DEPTH=8) -> full=1 after the 8th edge. Push 0x009: without WRAP, overflow=1 and tos_data=0x008. With WRAP, tos_data=0x009, count=8, and 8 pops return 0x009, 0x008 .. 0x002.
- Stack holding 0x0A0, 0x0B0: push=1 and pop=1 with push_data=0x0C0 -> count=2, tos_data=0x0C0; a following pop -> tos_data=0x0A0.
- Pop on empty -> underflow=1, count=0, tos_data=0. Later push 0x055 -> underflow is still 1. flush -> underflow=0, count=0.
- With count=5, assert flush together with push (0x777) -> count=0, empty=1, tos_data=0.
- With count=3, pulse rst_n low mid-cycle (asynchronously, not on an edge) -> count=0, empty=1, tos_data=0 before the next clk edge. After release, push 0x3FF -> tos_data=0x3FF.
